// File: rtl/demux22_pkg.sv
// Shared types and constants for the demux22_router burst demultiplexer.
package demux22_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic ROUTE_OUT0 = 1'b0;
  localparam logic ROUTE_OUT1 = 1'b1;

  localparam int STAT_W = 16;

  // Saturating increment used by the optional statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/demux22_fifo.sv
// Synchronous FIFO with registered head; a push into an empty FIFO is visible
// on the head the following cycle (no fall-through).
module demux22_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the heads read zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/demux22_router.sv
// Burst-granular 1:2 stream demultiplexer with a FIFO per output.
// Define DEMUX22_STATS_EN to add beat and burst counters (cnt0, cnt1, bursts).
module demux22_router
  import demux22_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_sel,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out0_data,
  output logic         out0_valid,
  input  logic         out0_ready,
  output logic [W-1:0] out1_data,
  output logic         out1_valid,
  input  logic         out1_ready
`ifdef DEMUX22_STATS_EN
  ,
  output logic [STAT_W-1:0] cnt0,
  output logic [STAT_W-1:0] cnt1,
  output logic [STAT_W-1:0] bursts
`endif
);
  state_t state;
  logic   route_q;
  logic   route;
  logic   full0, full1;
  logic   empty0, empty1;
  logic   accept;
  logic   push0, push1;

  // Valid/ready: a beat transfers on a rising edge where in_valid && in_ready;
  // an output head transfers where outN_valid && outN_ready. in_ready looks
  // only at the current count, never at a same-cycle pop.
  assign route    = (state == IDLE) ? in_sel : route_q;
  assign in_ready = !reset && ((route == ROUTE_OUT1) ? !full1 : !full0);
  assign accept   = in_valid && in_ready;
  assign push0    = accept && (route == ROUTE_OUT0);
  assign push1    = accept && (route == ROUTE_OUT1);

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;

  demux22_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .pop   (out0_ready),
    .wdata (in_data),
    .head  (out0_data),
    .full  (full0),
    .empty (empty0)
  );

  demux22_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (out1_ready),
    .wdata (in_data),
    .head  (out1_data),
    .full  (full1),
    .empty (empty1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      route_q <= ROUTE_OUT0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!in_last) begin
            state   <= BURST;
            route_q <= in_sel;
          end
        end
        BURST: begin
          if (in_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEMUX22_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0   <= '0;
      cnt1   <= '0;
      bursts <= '0;
    end else begin
      if (push0) cnt0 <= sat_inc(cnt0);
      if (push1) cnt1 <= sat_inc(cnt1);
      if (accept && in_last) bursts <= sat_inc(bursts);
    end
  end
`endif
endmodule

// File: tb/tb_demux22_router.sv
// Bench for demux22_router: directed vector table, reset-mid-burst sequence,
// and randomized traffic against a queue-based reference model.
module tb_demux22_router;
  localparam int W     = 2;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_sel, in_last, in_valid, in_ready;
  logic [W-1:0] out0_data, out1_data;
  logic         out0_valid, out0_ready, out1_valid, out1_ready;
`ifdef DEMUX22_STATS_EN
  logic [15:0]  cnt0, cnt1, bursts;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  demux22_router #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX22_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .bursts     (bursts)
`endif
  );

  typedef struct {
    logic         v, sel, last;
    logic [W-1:0] d;
    logic         r0, r1;
    logic         e_rdy, e_v0;
    logic [W-1:0] e_d0;
    logic         e_v1;
    logic [W-1:0] e_d1;
  } vec_t;

  vec_t tbl[15];

  // Reference model state: per-output queues and the destination of the open burst.
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  bit           m_active;
  bit           m_route;
  int           m_cnt0, m_cnt1, m_bursts;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic sel, input logic last,
                       input logic [W-1:0] d, input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = sel;
    in_last    = last;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic edge_to_negedge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    m_active = 0;
    m_route  = 0;
    m_cnt0   = 0;
    m_cnt1   = 0;
    m_bursts = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    #1;
    chk("in_ready_in_reset", 16'(in_ready), 16'd0);
    edge_to_negedge();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("rst_out0_valid", 16'(out0_valid), 16'd0);
    chk("rst_out1_valid", 16'(out1_valid), 16'd0);
    chk("rst_out0_data", 16'(out0_data), 16'd0);
    chk("rst_out1_data", 16'(out1_data), 16'd0);
`ifdef DEMUX22_STATS_EN
    chk("rst_cnt0", cnt0, 16'd0);
    chk("rst_cnt1", cnt1, 16'd0);
    chk("rst_bursts", bursts, 16'd0);
`endif
    model_reset();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    do_reset();

    // v sel last d r0 r1 | rdy v0 d0 v1 d1 (outputs after the edge)
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1, 2'b10};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 2'b10};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 2'b01};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].last, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 16'(in_ready), 16'(tbl[i].e_rdy));
      edge_to_negedge();
      chk($sformatf("tbl%0d_out0_valid", i), 16'(out0_valid), 16'(tbl[i].e_v0));
      chk($sformatf("tbl%0d_out1_valid", i), 16'(out1_valid), 16'(tbl[i].e_v1));
      if (tbl[i].e_v0) chk($sformatf("tbl%0d_out0_data", i), 16'(out0_data), 16'(tbl[i].e_d0));
      if (tbl[i].e_v1) chk($sformatf("tbl%0d_out1_data", i), 16'(out1_data), 16'(tbl[i].e_d1));
    end

    // Reset during beat 2 of a burst to out0; the next burst must follow in_sel.
    drive(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
    #1;
    chk("mid_beat1_ready", 16'(in_ready), 16'd1);
    edge_to_negedge();
    chk("mid_beat1_out0_valid", 16'(out0_valid), 16'd1);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    #1;
    chk("mid_reset_ready", 16'(in_ready), 16'd0);
    edge_to_negedge();
    reset = 1'b0;
    chk("mid_reset_out0_valid", 16'(out0_valid), 16'd0);
    chk("mid_reset_out1_valid", 16'(out1_valid), 16'd0);
    chk("mid_reset_out0_data", 16'(out0_data), 16'd0);
    chk("mid_reset_out1_data", 16'(out1_data), 16'd0);
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    #1;
    chk("post_reset_ready", 16'(in_ready), 16'd1);
    edge_to_negedge();
    chk("post_reset_out1_valid", 16'(out1_valid), 16'd1);
    chk("post_reset_out1_data", 16'(out1_data), 16'd3);
    chk("post_reset_out0_valid", 16'(out0_valid), 16'd0);
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    edge_to_negedge();
    chk("post_reset_beat2_out0_valid", 16'(out0_valid), 16'd0);

    // Randomized traffic against the queue model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic v, sel, last, r0, r1, rdy_exp, dest;
      logic [W-1:0] d;
      v    = ($urandom_range(0, 3) != 0);
      sel  = 1'($urandom_range(0, 1));
      last = ($urandom_range(0, 2) == 0);
      d    = W'($urandom_range(0, (1 << W) - 1));
      r0   = ((i % 64) < 16) ? 1'b0 : ($urandom_range(0, 2) != 0);
      r1   = ((i % 96) >= 60) ? 1'b0 : ($urandom_range(0, 2) != 0);
      dest = m_active ? m_route : sel;
      rdy_exp = dest ? (exp_q1.size() < DEPTH) : (exp_q0.size() < DEPTH);
      drive(v, sel, last, d, r0, r1);
      #1;
      chk("rnd_in_ready", 16'(in_ready), 16'(rdy_exp));
      if (r0 && exp_q0.size() > 0) void'(exp_q0.pop_front());
      if (r1 && exp_q1.size() > 0) void'(exp_q1.pop_front());
      if (v && rdy_exp) begin
        if (dest) begin exp_q1.push_back(d); m_cnt1++; end
        else      begin exp_q0.push_back(d); m_cnt0++; end
        if (last) begin
          m_active = 0;
          m_bursts++;
        end else if (!m_active) begin
          m_active = 1;
          m_route  = sel;
        end
      end
      edge_to_negedge();
      chk("rnd_out0_valid", 16'(out0_valid), 16'(exp_q0.size() > 0));
      chk("rnd_out1_valid", 16'(out1_valid), 16'(exp_q1.size() > 0));
      if (exp_q0.size() > 0) chk("rnd_out0_data", 16'(out0_data), 16'(exp_q0[0]));
      if (exp_q1.size() > 0) chk("rnd_out1_data", 16'(out1_data), 16'(exp_q1[0]));
    end
`ifdef DEMUX22_STATS_EN
    chk("stat_cnt0", cnt0, 16'(m_cnt0));
    chk("stat_cnt1", cnt1, 16'(m_cnt1));
    chk("stat_bursts", bursts, 16'(m_bursts));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
